// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if: issue strobe, architectural vector state and next-state bus
// between the vector register file (master) and the element-serial ALU (slave).
interface vector_alu_sequencer_if #(
    parameter int VLEN = 128
) ();
    logic                 start;
    logic [2:0]           op;
    logic [4:0]           vd;
    logic [4:0]           vs1;
    logic [4:0]           vs2;
    logic                 vm;
    logic [VLEN*32-1:0]   v_regs;
    logic [VLEN-1:0]      masks;
    logic [31:0]          vl;
    logic [31:0]          vstart;
    logic [2:0]           vsew;
    logic                 vill;
    logic [VLEN*32-1:0]   new_v_regs;
    logic [31:0]          new_vstart;
    logic                 busy;
    logic                 done;
    logic                 illegal;

    modport master (
        output start, op, vd, vs1, vs2, vm, v_regs, masks, vl, vstart, vsew, vill,
        input  new_v_regs, new_vstart, busy, done, illegal
    );

    modport slave (
        input  start, op, vd, vs1, vs2, vm, v_regs, masks, vl, vstart, vsew, vill,
        output new_v_regs, new_vstart, busy, done, illegal
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: element-serial vector integer ALU; rewrites one element of vd per
// cycle into the register file's next-state, passing state through unchanged otherwise.
module vector_alu_sequencer #(
    parameter int VLEN = 128
) (
    input logic                    SYS_clk,
    input logic                    SYS_reset_n,
    vector_alu_sequencer_if.slave  bus
);
    localparam int W  = VLEN * 32;
    localparam int IW = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       r_state, w_next;
    logic [31:0]  r_idx, r_end;
    logic [2:0]   r_op;
    logic [4:0]   r_vd, r_vs1, r_vs2;
    logic         r_vm, r_illegal;
    logic [1:0]   r_sew;
    logic         w_bad, w_active;
    logic [31:0]  w_vlmax, w_end, w_sew, w_emask, w_a, w_b, w_res, w_idx1;
    logic [31:0]  w_off_a, w_off_b, w_off_d;
    logic [W-1:0] w_wmask, w_wdata;

    assign w_bad   = bus.vill | (bus.vsew > 3'd2) | (bus.op == 3'd7);
    assign w_vlmax = 32'(VLEN) >> (32'd3 + 32'(bus.vsew));
    assign w_end   = (bus.vl < w_vlmax) ? bus.vl : w_vlmax;

    assign w_sew   = 32'd8 << r_sew;
    assign w_emask = (r_sew == 2'd2) ? '1 : (32'd1 << w_sew) - 32'd1;
    assign w_off_a = 32'(r_vs2) * 32'(VLEN) + r_idx * w_sew;
    assign w_off_b = 32'(r_vs1) * 32'(VLEN) + r_idx * w_sew;
    assign w_off_d = 32'(r_vd) * 32'(VLEN) + r_idx * w_sew;
    assign w_idx1  = r_idx + 32'd1;

    // Operands come from the live register file, so earlier element writes are already visible.
    assign w_a      = 32'(bus.v_regs >> w_off_a) & w_emask;
    assign w_b      = 32'(bus.v_regs >> w_off_b) & w_emask;
    assign w_active = r_vm | bus.masks[r_idx[IW-1:0]];

    assign w_res = ((r_op == 3'd0) ? w_a + w_b :
                    (r_op == 3'd1) ? w_a - w_b :
                    (r_op == 3'd2) ? (w_a & w_b) :
                    (r_op == 3'd3) ? (w_a | w_b) :
                    (r_op == 3'd4) ? (w_a ^ w_b) :
                    (r_op == 3'd5) ? ((w_a < w_b) ? w_a : w_b) :
                    ((w_a > w_b) ? w_a : w_b)) & w_emask;

    assign w_wmask = W'(w_emask) << w_off_d;
    assign w_wdata = W'(w_res) << w_off_d;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_idx     <= '0;
            r_end     <= '0;
            r_op      <= '0;
            r_vd      <= '0;
            r_vs1     <= '0;
            r_vs2     <= '0;
            r_vm      <= 1'b0;
            r_sew     <= '0;
            r_illegal <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_idx     <= bus.vstart;
            r_end     <= w_end;
            r_op      <= bus.op;
            r_vd      <= bus.vd;
            r_vs1     <= bus.vs1;
            r_vs2     <= bus.vs2;
            r_vm      <= bus.vm;
            r_sew     <= bus.vsew[1:0];
            r_illegal <= w_bad;
        end else if (r_state == EXEC) begin
            r_idx <= w_idx1;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.new_v_regs = bus.v_regs;
        bus.new_vstart = bus.vstart;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.illegal    = 1'b0;
        case (r_state)
            IDLE: if (bus.start) w_next = (w_bad || bus.vstart >= w_end) ? DONE : EXEC;
            EXEC: begin
                bus.busy       = 1'b1;
                bus.new_vstart = w_idx1;
                if (w_active) bus.new_v_regs = (bus.v_regs & ~w_wmask) | w_wdata;
                if (w_idx1 == r_end) w_next = DONE;
            end
            default: begin
                bus.done       = 1'b1;
                bus.illegal    = r_illegal;
                bus.new_vstart = '0;
                w_next         = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: randomized scoreboard bench; a register-file model reloads every
// cycle from the DUT's next-state outputs and an element-level reference predicts each result.
module tb_vector_alu_sequencer;
    localparam int VLEN = 128;
    localparam int W    = VLEN * 32;

    typedef struct {
        logic [W-1:0] rf;
        bit           ill;
        int           n;
        int           c0;
        int           vs0;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ld;
    logic [W-1:0] ld_rf, rf, rst_exp;
    logic [31:0]  ld_vs, vs;
    int           cyc = 0;
    int           total = 0, bad = 0, rst_req = 0, seen = 0, bcnt = 0;
    bit           fin = 1'b0;
    exp_t         q[$];

    vector_alu_sequencer_if #(.VLEN(VLEN)) bus ();

    vector_alu_sequencer #(.VLEN(VLEN)) dut (
        .SYS_clk     (clk),
        .SYS_reset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: reloads from the DUT every cycle unless the bench preloads it.
    always @(posedge clk) begin
        rf <= ld ? ld_rf : bus.new_v_regs;
        vs <= ld ? ld_vs : bus.new_vstart;
    end
    assign bus.v_regs = rf;
    assign bus.vstart = vs;

    function automatic logic [31:0] get_el(input logic [W-1:0] f, input int r, input int i, input int sew);
        int b = r * VLEN + i * sew;
        case (sew)
            8:       return 32'(f[b +: 8]);
            16:      return 32'(f[b +: 16]);
            default: return f[b +: 32];
        endcase
    endfunction

    function automatic logic [W-1:0] set_el(input logic [W-1:0] f, input int r, input int i, input int sew, input longint v);
        logic [W-1:0] g = f;
        int b = r * VLEN + i * sew;
        logic [31:0] x = 32'(v);
        case (sew)
            8:       g[b +: 8]  = x[7:0];
            16:      g[b +: 16] = x[15:0];
            default: g[b +: 32] = x;
        endcase
        return g;
    endfunction

    function automatic void model(input logic [W-1:0] f, input int op, input int vd, input int vs1,
                                  input int vs2, input bit vm, input logic [VLEN-1:0] m, input int vl,
                                  input int vst, input int vsew, input bit vill,
                                  output logic [W-1:0] o, output int n, output bit ill);
        longint md, a, b, r;
        int sew, e;
        o   = f;
        n   = 0;
        ill = vill || vsew > 2 || op == 7;
        if (ill) return;
        sew = 8 << vsew;
        e   = (vl < VLEN / sew) ? vl : VLEN / sew;
        md  = longint'(1) << sew;
        for (int i = vst; i < e; i++) begin
            n++;
            if (!vm && !m[i]) continue;
            a = longint'(get_el(o, vs2, i, sew));
            b = longint'(get_el(o, vs1, i, sew));
            case (op)
                0:       r = (a + b) % md;
                1:       r = (a - b + md) % md;
                2:       r = a & b;
                3:       r = a | b;
                4:       r = a ^ b;
                5:       r = (a < b) ? a : b;
                default: r = (a > b) ? a : b;
            endcase
            o = set_el(o, vd, i, sew, r);
        end
    endfunction

    function automatic logic [W-1:0] rand_rf();
        logic [W-1:0] f;
        for (int i = 0; i < VLEN; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic chk(input string n, input longint a, input longint x);
        total++;
        if (a != x) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, a, x);
        end
    endtask

    task automatic chk_rf(input string n, input logic [W-1:0] a, input logic [W-1:0] x);
        total++;
        if (a !== x) begin
            bad++;
            for (int i = 0; i < VLEN; i++)
                if (a[i*32 +: 32] !== x[i*32 +: 32]) begin
                    $display("FAIL %s word%0d got=%h want=%h", n, i, a[i*32 +: 32], x[i*32 +: 32]);
                    break;
                end
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_req != seen) begin
            seen = rst_req;
            chk("rst_busy", longint'(bus.busy), 0);
            chk("rst_done", longint'(bus.done), 0);
            chk("rst_illegal", longint'(bus.illegal), 0);
            chk_rf("rst_regs", rf, rst_exp);
            chk_rf("rst_pass", bus.new_v_regs, rf);
            chk("rst_vstart", longint'(bus.new_vstart), longint'(vs));
        end
        if (!rst_n) bcnt = 0;
        else if (bus.done) begin
            chk("done_expected", longint'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_rf("result", rf, e.rf);
                chk("illegal", longint'(bus.illegal), longint'(e.ill));
                chk("done_vstart", longint'(bus.new_vstart), 0);
                chk("latency", longint'(cyc - e.c0), longint'(e.n));
                chk("busy_cycles", longint'(bcnt), longint'(e.n));
                chk_rf("done_pass", bus.new_v_regs, rf);
            end
            bcnt = 0;
        end else if (bus.busy) begin
            bcnt++;
            if (q.size() > 0) chk("exec_vstart", longint'(bus.new_vstart), longint'(q[0].vs0 + cyc - q[0].c0 + 1));
        end else begin
            chk_rf("idle_pass", bus.new_v_regs, rf);
            chk("idle_vstart", longint'(bus.new_vstart), longint'(vs));
            chk("idle_illegal", longint'(bus.illegal), 0);
        end
        if (fin) begin
            chk("queue_empty", longint'(q.size()), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic issue(input logic [W-1:0] f, input int op, input int vd, input int vs1, input int vs2,
                         input bit vm, input logic [VLEN-1:0] m, input int vl, input int vst,
                         input int vsew, input bit vill, input bit pulse_mid, input bit pulse_done);
        exp_t e;
        int k;
        ld = 1'b1; ld_rf = f; ld_vs = 32'(vst);
        @(posedge clk); #1;
        ld = 1'b0;
        bus.op = 3'(op); bus.vd = 5'(vd); bus.vs1 = 5'(vs1); bus.vs2 = 5'(vs2); bus.vm = vm;
        bus.masks = m; bus.vl = 32'(vl); bus.vsew = 3'(vsew); bus.vill = vill; bus.start = 1'b1;
        model(f, op, vd, vs1, vs2, vm, m, vl, vst, vsew, vill, e.rf, e.n, e.ill);
        e.c0 = cyc + 1;
        e.vs0 = vst;
        q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (pulse_mid && e.n >= 3) begin
            @(posedge clk); #1;
            bus.start = 1'b1; bus.op = 3'(op ^ 1); bus.vl = 32'd1;
            @(posedge clk); #1;
            bus.start = 1'b0; bus.op = 3'(op); bus.vl = 32'(vl);
        end
        k = 0;
        while (!bus.done) begin
            @(negedge clk);
            if (++k > 300) begin
                $display("FAIL timeout waiting for done");
                $fatal(1);
            end
        end
        bus.start = pulse_done;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] f;
        int n;
        bit ill;
        rst_n = 1'b0; ld = 1'b1; ld_rf = rand_rf(); ld_vs = '0;
        bus.start = 1'b0; bus.op = '0; bus.vd = '0; bus.vs1 = '0; bus.vs2 = '0; bus.vm = 1'b1;
        bus.masks = '0; bus.vl = '0; bus.vsew = '0; bus.vill = 1'b0;
        @(posedge clk); #1;
        rst_exp = ld_rf;
        rst_req++;
        @(posedge clk); #1;
        rst_n = 1'b1; ld = 1'b0;

        // Unmasked add, SEW=32, with a start pulse mid-instruction that must be ignored
        f = rand_rf();
        for (int i = 0; i < 4; i++) begin
            f = set_el(f, 1, i, 32, longint'(i + 1));
            f = set_el(f, 2, i, 32, longint'((i + 1) * 10));
        end
        issue(f, 0, 3, 1, 2, 1'b1, '0, 4, 0, 2, 1'b0, 1'b1, 1'b0);

        // Masked sub, SEW=8: 0x05 - 0x07 wraps to 0xFE on active elements
        f = rand_rf();
        f[2*VLEN +: VLEN] = {(VLEN/8){8'h05}};
        f[1*VLEN +: VLEN] = {(VLEN/8){8'h07}};
        issue(f, 1, 4, 1, 2, 1'b0, VLEN'(5'b10101), 5, 0, 0, 1'b0, 1'b0, 1'b0);

        // Nonzero vstart, SEW=16 xor
        issue(rand_rf(), 4, 5, 6, 7, 1'b1, '0, 4, 2, 1, 1'b0, 1'b0, 1'b0);

        // vl beyond VLMAX, start pulsed during DONE
        issue(rand_rf(), 6, 8, 9, 10, 1'b1, '0, 100, 0, 2, 1'b0, 1'b0, 1'b1);

        // Rejected: vill, reserved op, illegal vsew; then an empty instruction
        issue(rand_rf(), 0, 3, 1, 2, 1'b1, '0, 4, 0, 2, 1'b1, 1'b0, 1'b0);
        issue(rand_rf(), 7, 3, 1, 2, 1'b1, '0, 4, 0, 2, 1'b0, 1'b0, 1'b0);
        issue(rand_rf(), 0, 3, 1, 2, 1'b1, '0, 4, 0, 3, 1'b0, 1'b0, 1'b0);
        issue(rand_rf(), 0, 3, 1, 2, 1'b1, '0, 3, 3, 2, 1'b0, 1'b0, 1'b0);

        // Fully overlapping operands
        issue(rand_rf(), 0, 2, 2, 2, 1'b1, '0, 16, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int vsew = ($urandom_range(0, 15) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            issue(rand_rf(), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                  int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), vsew,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset asserted after two of four EXEC cycles: only elements 0 and 1 survive
        f = rand_rf();
        ld = 1'b1; ld_rf = f; ld_vs = '0;
        @(posedge clk); #1;
        ld = 1'b0;
        bus.op = 3'd0; bus.vd = 5'd3; bus.vs1 = 5'd1; bus.vs2 = 5'd2; bus.vm = 1'b1;
        bus.vl = 32'd4; bus.vsew = 3'd2; bus.vill = 1'b0; bus.start = 1'b1;
        model(f, 0, 3, 1, 2, 1'b1, '0, 2, 0, 2, 1'b0, rst_exp, n, ill);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        rst_req++;
        @(posedge clk); #1;
        rst_req++;
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1 fin = 1'b1;
    end
endmodule

// File: doc/vector_alu_sequencer.md
Name: vector_alu_sequencer

Overview:
- Element-serial vector integer ALU sitting directly upstream of the vector register file.
- Reads the architectural vector state (v_regs, masks, vl, vstart, vsew, vill) that the register file presents each cycle.
- Drives the register file's next-state inputs new_v_regs and new_vstart, writing one element per cycle until the instruction completes.
- When idle it passes state through unchanged, because the register file reloads every cycle.

Parameters:
- VLEN, 128, bits per vector register. Register file width is VLEN*32; mask width is VLEN.

Ports:
- SYS_clk  in  1  system clock, rising edge
- SYS_reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle instruction issue strobe
- op  in  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 minu, 6 maxu, 7 reserved
- vd, vs1, vs2  in  5 each  destination and source register indices
- vm  in  1  0 = masked by masks[i], 1 = unmasked
- v_regs  in  VLEN*32  current register file contents
- masks  in  VLEN  current mask register
- vl, vstart  in  32 each  current vector length and start index
- vsew  in  3  SEW encoding: 000=8, 001=16, 010=32; others illegal
- vill  in  1  vtype illegal flag
- new_v_regs  out  VLEN*32  next register file contents
- new_vstart  out  32  next vstart
- busy  out  1  high in EXEC
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse, coincident with done, on a rejected instruction

Behaviour:
- States: IDLE, EXEC, DONE. Reset (async, SYS_reset_n=0):
  - state=IDLE; idx=0; latched fields cleared.
  - busy=0, done=0, illegal=0.
  - Reset asserted mid-EXEC aborts immediately. No further element writes occur; outputs revert to pass-through.
- IDLE:
  - new_v_regs=v_regs and new_vstart=vstart, both combinational pass-through.
  - On start=1, latch op, vd, vs1, vs2, vm and SEW.
  - Compute end = min(vl, VLMAX) with VLMAX = VLEN/SEW.
  - Set idx=vstart.
- Transitions from IDLE on start:
  - vill=1, vsew>2, or op=7: go to DONE with illegal set. No writes.
  - Otherwise, vstart>=end: go to DONE with no writes.
  - Otherwise: go to EXEC.
- EXEC, per cycle:
  - Element i=idx occupies bits [r*VLEN + i*SEW +: SEW].
  - Operands a = element i of vs2, b = element i of vs1, both read from current v_regs. Writes from the previous cycle are already visible because the register file has reloaded.
  - Element is active if vm=1 or masks[i]=1.
  - Active: new_v_regs = v_regs with element i of vd replaced by result.
  - Inactive: new_v_regs = v_regs (mask-undisturbed).
  - Results truncated to SEW. add/sub wrap modulo 2^SEW; sub = vs2 - vs1. minu/maxu are unsigned compares.
  - new_vstart = idx+1; idx increments each cycle.
  - When idx+1 == end, go to DONE.
  - Elements >= end are never written (tail-undisturbed).
  - busy=1.
- DONE (one cycle):
  - done=1; illegal=1 only on the rejected path.
  - new_v_regs=v_regs; new_vstart=0.
  - Then go to IDLE.
- start while busy or in DONE: ignored, not queued.
- Overlapping vd with vs1/vs2 is legal. The element-wise read-before-write order gives correct results.
- Latency: an N-element instruction gives done N+1 cycles after the start edge. The rejected and empty cases give done 1 cycle after start.

Test Plan:
- Unmasked add, SEW=32, VLEN=128: v1=[1,2,3,4], v2=[10,20,30,40], vl=4, vstart=0, vm=1, op=add, vd=3 -> v3=[11,22,33,44]. busy for 4 cycles; done on 5th cycle; final vstart=0.
- Masked sub, SEW=8: vl=5, masks=0b10101, vs2 elements=0x05, vs1 elements=0x07 -> elements 0, 2, 4 of vd = 0xFE. Elements 1, 3 and 5..15 unchanged.
- vstart=2, vl=4, SEW=16, op=xor -> only elements 2 and 3 written; new_vstart sequence 3, 4, then 0; done after 2 EXEC cycles.
- vl=100, SEW=32 (VLMAX=4) -> exactly 4 elements written, then done.
- vill=1 on start -> done=1 and illegal=1 next cycle, v_regs unchanged. Repeat with op=7 and with vsew=011 -> same response.
- Assert SYS_reset_n low after 2 of 4 EXEC cycles -> busy=0 immediately, only elements 0 and 1 modified. start pulsed during EXEC is ignored.
